alarm_ringer: RTL and testbench

- Consumer of the alarm trigger. Turns the level-type `alarm` output of the alarm comparator into an annunciation sequence.
- Annunciation: pulsed buzzer drive, auto-timeout, snooze with a bounded repeat count, and stop.
- Sits between the alarm comparator and the board buzzer/LED pins. Button inputs arrive as one-cycle edge pulses from the existing debouncer/edge-detector path.

---
 rtl/alarm_ringer.sv | 278 +++++++++++++++++++++++++++
 tb/tb_alarm_ringer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ringer.sv
// ---------------------------------------------------------------------------
// alarm_ringer
//
// Turns the level-type alarm trigger from the alarm comparator into an
// annunciation sequence: a pulsed buzzer while ringing, automatic timeout,
// snooze with a bounded repeat count, and stop.
//
// Ports:
//   clk           clock
//   reset         asynchronous, active-low reset (asserted when 0)
//   alarm_in      alarm trigger level (high for the whole matching second)
//   enable        alarm armed switch; 0 forces IDLE and clears the snooze count
//   stop_btn      one-cycle stop pulse
//   snooze_btn    one-cycle snooze pulse
//   buzzer        buzzer drive
//   ringing       high while in RING
//   snoozing      high while in SNOOZE
//   snooze_count  snoozes used in the current alarm event
//
// Optional feature (compile-time macro ALARM_RINGER_ESCALATE_EN):
//   once RING has lasted RING_SECS/2 seconds the buzzer is held at a constant
//   1 until RING is left. Without the macro the buzzer keeps toggling for the
//   whole RING duration.
// ---------------------------------------------------------------------------
module alarm_ringer #(
    parameter int SEC_CYCLES  = 100000000,  // clk cycles per second
    parameter int BEEP_CYCLES = 25000000,   // clk cycles per buzzer half-period
    parameter int RING_SECS   = 60,         // seconds in RING before timeout
    parameter int SNOOZE_SECS = 300,        // seconds in SNOOZE before re-ring
    parameter int MAX_SNOOZE  = 3           // snoozes allowed per event (1..3)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alarm_in,
    input  logic       enable,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snooze_count
);

    // -----------------------------------------------------------------------
    // Derived widths and terminal counts
    // -----------------------------------------------------------------------
    localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int CYC_W    = (SEC_CYCLES  > 1) ? $clog2(SEC_CYCLES)  : 1;
    localparam int BEEP_W   = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam int SEC_W    = $clog2(MAX_SECS + 1);

    localparam logic [CYC_W-1:0]  CYC_LAST    = CYC_W'(SEC_CYCLES - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST   = BEEP_W'(BEEP_CYCLES - 1);
    localparam logic [SEC_W-1:0]  RING_LAST   = SEC_W'(RING_SECS - 1);
    localparam logic [SEC_W-1:0]  SNOOZE_LAST = SEC_W'(SNOOZE_SECS - 1);
    localparam logic [1:0]        SNOOZE_MAX  = 2'(MAX_SNOOZE);

`ifdef ALARM_RINGER_ESCALATE_EN
    localparam logic [SEC_W-1:0]  ESC_SECS    = SEC_W'(RING_SECS / 2);
`endif

    // FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;

    // -----------------------------------------------------------------------
    // State and counter registers
    // -----------------------------------------------------------------------
    logic [1:0]        state_q,    state_d;
    logic              alarm_prev_q;
    logic [CYC_W-1:0]  cyc_q,      cyc_d;
    logic [BEEP_W-1:0] beep_q,     beep_d;
    logic [SEC_W-1:0]  sec_q,      sec_d;
    logic [1:0]        cnt_q,      cnt_d;
    logic              buzzer_q,   buzzer_d;
    logic              ringing_q,  ringing_d;
    logic              snoozing_q, snoozing_d;
`ifdef ALARM_RINGER_ESCALATE_EN
    logic              esc_q,      esc_d;
`endif

    // Free-running advance values, used by whichever state is counting
    logic              rise;
    logic              sec_tick;
    logic              beep_wrap;
    logic [CYC_W-1:0]  cyc_adv;
    logic [BEEP_W-1:0] beep_adv;
    logic [SEC_W-1:0]  sec_adv;

    assign rise      = alarm_in & ~alarm_prev_q;
    assign sec_tick  = (cyc_q == CYC_LAST);
    assign beep_wrap = (beep_q == BEEP_LAST);
    assign cyc_adv   = sec_tick  ? '0 : cyc_q + CYC_W'(1);
    assign beep_adv  = beep_wrap ? '0 : beep_q + BEEP_W'(1);
    assign sec_adv   = sec_tick  ? sec_q + SEC_W'(1) : sec_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if tree leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        beep_d   = beep_q;
        sec_d    = sec_q;
        cnt_d    = cnt_q;
        buzzer_d = buzzer_q;
`ifdef ALARM_RINGER_ESCALATE_EN
        esc_d    = esc_q;
`endif

        if (!enable) begin
            // Disarming always wins and ends the current alarm event.
            state_d  = ST_IDLE;
            cyc_d    = '0;
            beep_d   = '0;
            sec_d    = '0;
            cnt_d    = '0;
            buzzer_d = 1'b0;
`ifdef ALARM_RINGER_ESCALATE_EN
            esc_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Only a fresh rising edge starts an event; a level still
                    // high after stop or timeout does not re-trigger.
                    if (rise) begin
                        state_d  = ST_RING;
                        cyc_d    = '0;
                        beep_d   = '0;
                        sec_d    = '0;
                        buzzer_d = 1'b1;
`ifdef ALARM_RINGER_ESCALATE_EN
                        esc_d    = (ESC_SECS == '0);
`endif
                    end
                end

                ST_RING: begin
                    if (stop_btn) begin
                        state_d  = ST_IDLE;
                        cyc_d    = '0;
                        beep_d   = '0;
                        sec_d    = '0;
                        cnt_d    = '0;
                        buzzer_d = 1'b0;
`ifdef ALARM_RINGER_ESCALATE_EN
                        esc_d    = 1'b0;
`endif
                    end else if (snooze_btn && (cnt_q < SNOOZE_MAX)) begin
                        state_d  = ST_SNOOZE;
                        cyc_d    = '0;
                        beep_d   = '0;
                        sec_d    = '0;
                        cnt_d    = cnt_q + 2'd1;
                        buzzer_d = 1'b0;
`ifdef ALARM_RINGER_ESCALATE_EN
                        esc_d    = 1'b0;
`endif
                    end else if (sec_tick && (sec_q == RING_LAST)) begin
                        // Leave on the edge that would make the second count
                        // reach RING_SECS, so RING lasts exactly RING_SECS s.
                        state_d  = ST_IDLE;
                        cyc_d    = '0;
                        beep_d   = '0;
                        sec_d    = '0;
                        cnt_d    = '0;
                        buzzer_d = 1'b0;
`ifdef ALARM_RINGER_ESCALATE_EN
                        esc_d    = 1'b0;
`endif
                    end else begin
                        // Normal ringing (also covers an exhausted snooze press).
                        cyc_d    = cyc_adv;
                        sec_d    = sec_adv;
                        beep_d   = beep_adv;
                        buzzer_d = beep_wrap ? ~buzzer_q : buzzer_q;
`ifdef ALARM_RINGER_ESCALATE_EN
                        esc_d    = esc_q | (sec_adv >= ESC_SECS);
                        if (esc_d) begin
                            buzzer_d = 1'b1;
                        end
`endif
                    end
                end

                ST_SNOOZE: begin
                    if (stop_btn) begin
                        state_d  = ST_IDLE;
                        cyc_d    = '0;
                        beep_d   = '0;
                        sec_d    = '0;
                        cnt_d    = '0;
                        buzzer_d = 1'b0;
                    end else if (sec_tick && (sec_q == SNOOZE_LAST)) begin
                        // Snooze expired: ring again, keeping the snooze count.
                        state_d  = ST_RING;
                        cyc_d    = '0;
                        beep_d   = '0;
                        sec_d    = '0;
                        buzzer_d = 1'b1;
`ifdef ALARM_RINGER_ESCALATE_EN
                        esc_d    = (ESC_SECS == '0);
`endif
                    end else begin
                        cyc_d    = cyc_adv;
                        sec_d    = sec_adv;
                        buzzer_d = 1'b0;
                    end
                end

                default: begin
                    state_d  = ST_IDLE;
                    cyc_d    = '0;
                    beep_d   = '0;
                    sec_d    = '0;
                    cnt_d    = '0;
                    buzzer_d = 1'b0;
`ifdef ALARM_RINGER_ESCALATE_EN
                    esc_d    = 1'b0;
`endif
                end
            endcase
        end

        // Status outputs are decoded from the next state and registered with it.
        ringing_d  = (state_d == ST_RING);
        snoozing_d = (state_d == ST_SNOOZE);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            alarm_prev_q <= 1'b0;
            cyc_q        <= '0;
            beep_q       <= '0;
            sec_q        <= '0;
            cnt_q        <= '0;
            buzzer_q     <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            alarm_prev_q <= alarm_in;
            cyc_q        <= cyc_d;
            beep_q       <= beep_d;
            sec_q        <= sec_d;
            cnt_q        <= cnt_d;
            buzzer_q     <= buzzer_d;
            ringing_q    <= ringing_d;
            snoozing_q   <= snoozing_d;
        end
    end

`ifdef ALARM_RINGER_ESCALATE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            esc_q <= 1'b0;
        end else begin
            esc_q <= esc_d;
        end
    end
`endif

    assign buzzer       = buzzer_q;
    assign ringing      = ringing_q;
    assign snoozing     = snoozing_q;
    assign snooze_count = cnt_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// ---------------------------------------------------------------------------
// tb_alarm_ringer
//
// Self-checking bench for alarm_ringer with small timing parameters.
// Vectors of {inputs, expected outputs} are queued per scenario; each vector
// is driven on the falling edge, its expectation is pushed to a scoreboard
// queue, and after the following rising edge the expectation is popped and
// compared with the DUT outputs. Reset behaviour is checked by hand.
// ---------------------------------------------------------------------------
module tb_alarm_ringer;

    localparam int SEC_CYCLES  = 10;
    localparam int BEEP_CYCLES = 2;
    localparam int RING_SECS   = 4;
    localparam int SNOOZE_SECS = 3;
    localparam int MAX_SNOOZE  = 2;
    localparam int RING_LEN    = SEC_CYCLES * RING_SECS;    // 40 cycles
    localparam int SNOOZE_LEN  = SEC_CYCLES * SNOOZE_SECS;  // 30 cycles

    logic       clk = 1'b0;
    logic       reset;
    logic       alarm_in;
    logic       enable;
    logic       stop_btn;
    logic       snooze_btn;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_count;

    always #5 clk = ~clk;

    alarm_ringer #(
        .SEC_CYCLES  (SEC_CYCLES),
        .BEEP_CYCLES (BEEP_CYCLES),
        .RING_SECS   (RING_SECS),
        .SNOOZE_SECS (SNOOZE_SECS),
        .MAX_SNOOZE  (MAX_SNOOZE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alarm_in     (alarm_in),
        .enable       (enable),
        .stop_btn     (stop_btn),
        .snooze_btn   (snooze_btn),
        .buzzer       (buzzer),
        .ringing      (ringing),
        .snoozing     (snoozing),
        .snooze_count (snooze_count)
    );

    typedef struct {
        logic       alarm_in;
        logic       enable;
        logic       stop_btn;
        logic       snooze_btn;
        logic       buzzer;
        logic       ringing;
        logic       snoozing;
        logic [1:0] count;
    } vec_t;

    typedef struct {
        logic       buzzer;
        logic       ringing;
        logic       snoozing;
        logic [1:0] count;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected buzzer k cycles after RING entry: starts at 1, toggles every
    // BEEP_CYCLES; with escalation it is held at 1 from RING_SECS/2 seconds.
    function automatic logic ring_buz(input int k);
`ifdef ALARM_RINGER_ESCALATE_EN
        if (k >= (RING_SECS / 2) * SEC_CYCLES) return 1'b1;
`endif
        return ((k / BEEP_CYCLES) % 2) == 0;
    endfunction

    task automatic add(input logic a, input logic e, input logic st, input logic sn,
                       input logic bz, input logic rg, input logic sz, input logic [1:0] c);
        vec_t v;
        v.alarm_in   = a;
        v.enable     = e;
        v.stop_btn   = st;
        v.snooze_btn = sn;
        v.buzzer     = bz;
        v.ringing    = rg;
        v.snoozing   = sz;
        v.count      = c;
        vecs.push_back(v);
    endtask

    // RING cycles k0..k1 with no buttons.
    task automatic add_ring(input int k0, input int k1, input logic a, input logic [1:0] c);
        for (int k = k0; k <= k1; k++) add(a, 1'b1, 1'b0, 1'b0, ring_buz(k), 1'b1, 1'b0, c);
    endtask

    // SNOOZE cycles s0..s1 with no buttons.
    task automatic add_snooze(input int s0, input int s1, input logic [1:0] c);
        for (int s = s0; s <= s1; s++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c);
    endtask

    task automatic add_idle(input int n, input logic a);
        for (int i = 0; i < n; i++) add(a, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic run_vecs(input string tag);
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            alarm_in   = vecs[i].alarm_in;
            enable     = vecs[i].enable;
            stop_btn   = vecs[i].stop_btn;
            snooze_btn = vecs[i].snooze_btn;
            e.buzzer   = vecs[i].buzzer;
            e.ringing  = vecs[i].ringing;
            e.snoozing = vecs[i].snoozing;
            e.count    = vecs[i].count;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s[%0d] buzzer", tag, i),       {1'b0, buzzer},   {1'b0, e.buzzer});
            check($sformatf("%s[%0d] ringing", tag, i),      {1'b0, ringing},  {1'b0, e.ringing});
            check($sformatf("%s[%0d] snoozing", tag, i),     {1'b0, snoozing}, {1'b0, e.snoozing});
            check($sformatf("%s[%0d] snooze_count", tag, i), snooze_count,     e.count);
        end
        vecs.delete();
        @(negedge clk);
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " buzzer"},       {1'b0, buzzer},   2'd0);
        check({tag, " ringing"},      {1'b0, ringing},  2'd0);
        check({tag, " snoozing"},     {1'b0, snoozing}, 2'd0);
        check({tag, " snooze_count"}, snooze_count,     2'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        alarm_in   = 1'b0;
        enable     = 1'b0;
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;

        // 1. Reset held low for three cycles, outputs all zero.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_hold");
        @(negedge clk);
        reset = 1'b1;

        // Idle after reset; buttons and a rise while disarmed are ignored.
        add(0, 0, 0, 0, 0, 0, 0, 2'd0);
        add(0, 1, 0, 0, 0, 0, 0, 2'd0);
        add(0, 1, 1, 0, 0, 0, 0, 2'd0);  // stop in IDLE
        add(0, 1, 0, 1, 0, 0, 0, 2'd0);  // snooze in IDLE
        add(1, 0, 0, 0, 0, 0, 0, 2'd0);  // rise while disarmed
        add(0, 0, 0, 0, 0, 0, 0, 2'd0);
        add(0, 1, 0, 0, 0, 0, 0, 2'd0);
        run_vecs("t1_idle");

        // 2. Rise, alarm held 15 cycles, full RING to automatic timeout.
        for (int k = 0; k < RING_LEN; k++)
            add(k < 15, 1, 0, 0, ring_buz(k), 1, 0, 2'd0);
        add_idle(4, 1'b0);                 // timeout edge then quiet idle
        run_vecs("t2_timeout");

        // 3. Snooze at RING cycle 5, re-ring after SNOOZE_SECS.
        add(1, 1, 0, 0, 1, 1, 0, 2'd0);   // rise -> RING k=0
        add_ring(1, 4, 1'b0, 2'd0);
        add(0, 1, 0, 1, 0, 0, 1, 2'd1);   // snooze -> SNOOZE s=0
        add_snooze(1, SNOOZE_LEN - 1, 2'd1);
        add(0, 1, 0, 0, 1, 1, 0, 2'd1);   // back to RING, buzzer=1
        // 4. Second snooze, then snooze limit reached in the third RING.
        add_ring(1, 1, 1'b0, 2'd1);
        add(0, 1, 0, 1, 0, 0, 1, 2'd2);
        add_snooze(1, SNOOZE_LEN - 1, 2'd2);
        add(0, 1, 0, 0, 1, 1, 0, 2'd2);
        add_ring(1, 2, 1'b1, 2'd2);        // rise during RING is ignored
        add(1, 1, 0, 1, ring_buz(3), 1, 0, 2'd2);  // snooze ignored at limit
        add_ring(4, 4, 1'b1, 2'd2);
        add(1, 1, 1, 0, 0, 0, 0, 2'd0);   // stop, alarm level still high
        add_idle(3, 1'b1);                 // held level does not re-trigger
        add_idle(1, 1'b0);
        run_vecs("t3_t4_snooze");

        // 5a. enable=0 during SNOOZE forces IDLE on the next edge.
        add(1, 1, 0, 0, 1, 1, 0, 2'd0);
        add_ring(1, 2, 1'b0, 2'd0);
        add(0, 1, 0, 1, 0, 0, 1, 2'd1);
        add_snooze(1, 4, 2'd1);
        add(0, 0, 0, 0, 0, 0, 0, 2'd0);
        add_idle(2, 1'b0);
        // 5b. Stop and snooze together during RING: stop wins.
        add(1, 1, 0, 0, 1, 1, 0, 2'd0);
        add(0, 1, 0, 1, 0, 0, 1, 2'd1);
        add_snooze(1, SNOOZE_LEN - 1, 2'd1);
        add(0, 1, 0, 0, 1, 1, 0, 2'd1);
        add_ring(1, 1, 1'b0, 2'd1);
        add(0, 1, 1, 1, 0, 0, 0, 2'd0);
        add_idle(2, 1'b0);
        // 5c. Stop during SNOOZE.
        add(1, 1, 0, 0, 1, 1, 0, 2'd0);
        add(0, 1, 0, 1, 0, 0, 1, 2'd1);
        add_snooze(1, 1, 2'd1);
        add(0, 1, 1, 0, 0, 0, 0, 2'd0);
        add_idle(1, 1'b0);
        // 5d. enable=0 during RING.
        add(1, 1, 0, 0, 1, 1, 0, 2'd0);
        add_ring(1, 2, 1'b0, 2'd0);
        add(0, 0, 0, 0, 0, 0, 0, 2'd0);
        add_idle(1, 1'b0);
        run_vecs("t5_priority");

        // 6. Asynchronous reset in the middle of RING.
        add(1, 1, 0, 0, 1, 1, 0, 2'd0);
        add_ring(1, 5, 1'b0, 2'd0);
        run_vecs("t6_pre_reset");
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        @(posedge clk);
        #1;
        check_all_zero("t6_reset_held");
        @(negedge clk);
        reset = 1'b1;
        add_idle(3, 1'b0);
        add(1, 1, 0, 0, 1, 1, 0, 2'd0);   // ring again after reset
        add_ring(1, 3, 1'b0, 2'd0);
        add(0, 1, 1, 0, 0, 0, 0, 2'd0);
        run_vecs("t6_post_reset");

        check("scoreboard_drained", 2'(exp_q.size()), 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
